// File: rtl/rr_x_in_pkg.sv
// Shared definitions for the round-robin input arbiter: state encoding and default sizing.
package rr_x_in_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_e;

    localparam int IO_SIZE_DEF = 5;
    localparam int IO_W_DEF    = 3;

endpackage

// File: rtl/rr_x_in_arbiter_if.sv
// Request/grant bundle between the router input ports and the output-port arbiter.
interface rr_x_in_arbiter_if
    import rr_x_in_pkg::*;
#(
    parameter int IO_SIZE = IO_SIZE_DEF,
    parameter int IO_w    = IO_W_DEF
);

    logic [IO_SIZE-1:0] req_i;
    logic               release_i;
    logic [IO_SIZE-1:0] grant_o;
    logic               grant_valid_o;
    logic [IO_w-1:0]    grant_id_o;

    modport master (
        output req_i,
        output release_i,
        input  grant_o,
        input  grant_valid_o,
        input  grant_id_o
    );

    modport slave (
        input  req_i,
        input  release_i,
        output grant_o,
        output grant_valid_o,
        output grant_id_o
    );

endinterface

// File: rtl/rr_x_in_arbiter_rot.sv
// Combinational rotators modulo IO_SIZE; shift_i must be below IO_SIZE.
// Doubling the vector keeps the wrap exact for non-power-of-two sizes.
module rot_right_x_in #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic [IO_SIZE-1:0] data_i,
    input  logic [IO_w-1:0]    shift_i,
    output logic [IO_SIZE-1:0] data_o
);

    assign data_o = IO_SIZE'({data_i, data_i} >> shift_i);

endmodule

module rot_left_x_in #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic [IO_SIZE-1:0] data_i,
    input  logic [IO_w-1:0]    shift_i,
    output logic [IO_SIZE-1:0] data_o
);

    assign data_o = IO_SIZE'(({data_i, data_i} << shift_i) >> IO_SIZE);

endmodule

// File: rtl/rr_x_in_arbiter.sv
// Registered round-robin arbiter: grants one requester and holds it until release or request drop.
//
// state      | meaning
// ST_IDLE    | no owner; arbitrate on any request, starting just past ptr
// ST_GRANTED | owner holds grant until release or its request drops
module rr_x_in_arbiter
    import rr_x_in_pkg::*;
#(
    parameter int IO_SIZE = IO_SIZE_DEF,
    parameter int IO_w    = IO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_x_in_arbiter_if.slave arb
);

    arb_state_e          state_q, state_d;
    logic [IO_w-1:0]     ptr_q, ptr_d;
    logic [IO_SIZE-1:0]  grant_q, grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IO_w-1:0]     grant_id_q, grant_id_d;

    logic [IO_w-1:0]     start;
    logic [IO_SIZE-1:0]  req_rot;
    logic [IO_w-1:0]     k;
    logic [IO_SIZE-1:0]  onehot_rel;
    logic [IO_SIZE-1:0]  onehot;
    logic [IO_w:0]       sum;
    logic [IO_w-1:0]     winner;
    logic                grant_end;

    assign start = (ptr_q == IO_w'(IO_SIZE - 1)) ? '0 : ptr_q + 1'b1;

    rot_right_x_in #(.IO_SIZE(IO_SIZE), .IO_w(IO_w)) u_rot_right (
        .data_i  (arb.req_i),
        .shift_i (start),
        .data_o  (req_rot)
    );

    always_comb begin
        k = '0;
        for (int i = IO_SIZE - 1; i >= 0; i--) begin
            if (req_rot[i]) k = IO_w'(i);
        end
    end

    assign onehot_rel = IO_SIZE'(1) << k;

    rot_left_x_in #(.IO_SIZE(IO_SIZE), .IO_w(IO_w)) u_rot_left (
        .data_i  (onehot_rel),
        .shift_i (k == k ? start : start),
        .data_o  (onehot)
    );

    assign sum    = {1'b0, start} + {1'b0, k};
    assign winner = (sum >= (IO_w+1)'(IO_SIZE)) ? IO_w'(sum - (IO_w+1)'(IO_SIZE)) : IO_w'(sum);

    // The grant is one-hot, so masking req with it is the owner's own request bit.
    assign grant_end = arb.release_i | ~(|(arb.req_i & grant_q));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb.req_i) begin
                    grant_d       = onehot;
                    grant_id_d    = winner;
                    grant_valid_d = 1'b1;
                    state_d       = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (grant_end) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IO_w'(IO_SIZE - 1);
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign arb.grant_o       = grant_q;
    assign arb.grant_valid_o = grant_valid_q;
    assign arb.grant_id_o    = grant_id_q;

endmodule

// File: doc/rr_x_in_arbiter.md
# rr_x_in_arbiter

Registered round-robin arbiter for IO_SIZE requesters, used at NoC router output ports to pick one input and hold the grant until it is released. Requests are right-rotated so the search starts just past the last winner. The lowest set bit is found, and the one-hot result is left-rotated back to absolute position and registered. The grant is held until the owner releases it, then the priority pointer advances.

## Interface
- IO_SIZE, 5, number of requesters (≥2)
- IO_w, 3, index width; ≥ clog2(IO_SIZE)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  IO_SIZE  request vector, bit i = requester i
- release  in  1  current owner finishes; sampled only while grant_valid=1
- grant  out  IO_SIZE  registered one-hot grant; all-zero when idle
- grant_valid  out  1  registered; 1 while a grant is held
- grant_id  out  IO_w  registered binary index of the owner; meaningful only when grant_valid=1

## Operation
- State register with two states: IDLE and GRANTED. Pointer register ptr (IO_w bits) holds the last winner.
- Reset values:
  - state=IDLE
  - ptr=IO_SIZE-1, so the first search starts at index 0
  - grant=0, grant_valid=0, grant_id=0
- Search start: start = (ptr==IO_SIZE-1) ? 0 : ptr+1. Compute this explicitly; never use a power-of-two wrap.
- Rotation: rot = ror(req, start), with rotations modulo IO_SIZE (rol/ror of a zero-wide shift is the identity).
- Priority encode: k = lowest set bit of rot. Then:
  - onehot = rol(1<<k, start)
  - winner = start+k, minus IO_SIZE if the sum is ≥ IO_SIZE. Compute in IO_w+1 bits.
- IDLE:
  - If req≠0: grant<=onehot, grant_id<=winner, grant_valid<=1, state<=GRANTED.
  - Otherwise stay in IDLE with outputs at 0.
- GRANTED: the end condition is end = release | ~req[grant_id].
  - If end: grant<=0, grant_valid<=0, ptr<=grant_id, state<=IDLE.
  - Otherwise hold all outputs.
  - Requests from other requesters are ignored while GRANTED.
- ptr changes only on grant end, so a winner that is still holding does not shift priority.
- No starvation: any requester that stays asserted is granted within IO_SIZE-1 intervening grants.

## Timing
- Arbitration latency is 1 cycle. req is sampled at edge N; grant is visible after edge N.
- Release latency is 1 cycle. release is sampled at edge M; grant is 0 after edge M.
- Back-to-back re-arbitration has one idle bubble: IDLE lasts at least one cycle between grants. The next winner is visible after edge M+1.
- release asserted in IDLE is ignored.
- Simultaneous release and req drop are treated as a single end.
- Reset mid-grant: grant, grant_valid and grant_id clear immediately and asynchronously. ptr returns to IO_SIZE-1. Arbitration resumes on the first edge after rst_n rises.
- All outputs come straight from flops; there is no combinational path from req or release to the outputs.

## Structure
- Shared package (rr_x_in_pkg) holds:
  - the state encoding, ST_IDLE=1'b0 and ST_GRANTED=1'b1
  - the default IO_SIZE/IO_w constants
- Sub-module rot_left_x_in: combinational left rotate with the same parameters. It is the inverse of the existing right-rotate block and maps the one-hot back to absolute position. The existing right-rotate block is instantiated for the request alignment.
- The priority encoder and the winner adder are inline, combinational.

## Test plan
- Reset: hold rst_n=0 with req=5'b11111. Required: grant=0, grant_valid=0, grant_id=0. Release rst_n; 1 cycle later grant=5'b00001, grant_id=0.
- Single requester: req=5'b00100 for 3 cycles, then release=1 for 1 cycle. Required:
  - grant=5'b00100 for 3 cycles, then 0
  - next search starts at 3
  - with req still 5'b00100, re-granted after the bubble
- Full rotation: req=5'b11111 held, release pulsed each time a grant appears. Required:
  - grant_id sequence 0,1,2,3,4,0, with one idle cycle between grants
  - IO_SIZE-1→0 wrap
- Skip and wrap: ptr=3 (after a grant to 3), req=5'b01010. Required: the winner is 1, not 3, and grant=5'b00010.
- Implicit end: owner 2 drops req[2] without release while req=5'b10000 is pending. Required: grant clears next cycle; the cycle after, grant=5'b10000.
- Reset mid-grant: assert rst_n=0 while grant_id=3. Required: outputs are 0 immediately. After rst_n rises with req=5'b11000, the winner is 3, since ptr reset gives a start of 0.
